// File: rtl/dma_2d_pkg.sv
// Shared types for the 2D DMA descriptor scheduler: FSM states, error codes
// and the packed descriptor layout stored in the queue.
package dma_2d_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_START,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DESC    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int unsigned DESC_W      = 192;
  localparam int unsigned OFF_SRC     = 0;
  localparam int unsigned OFF_DST     = 32;
  localparam int unsigned OFF_WIDTH   = 64;
  localparam int unsigned OFF_HEIGHT  = 96;
  localparam int unsigned OFF_SSTRIDE = 128;
  localparam int unsigned OFF_DSTRIDE = 160;

  // Field order matches the offsets above (src in the low word).
  typedef struct packed {
    logic [31:0] dst_stride;
    logic [31:0] src_stride;
    logic [31:0] height;
    logic [31:0] width;
    logic [31:0] dst;
    logic [31:0] src;
  } desc_t;

endpackage

// File: rtl/dma_2d_desc_scheduler_fifo.sv
// Synchronous descriptor FIFO with flush; level is one bit wider than the
// pointers so full and empty are distinguishable.
module dma_desc_fifo #(
  parameter int unsigned C_DEPTH = 4,
  parameter int unsigned C_W     = 192
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [C_W-1:0]               data_i,
  output logic [C_W-1:0]               data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(C_DEPTH):0]     level_o
);

  localparam int unsigned PW = $clog2(C_DEPTH);

  logic [C_W-1:0] mem_q [C_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PW:0]    level_q;
  logic           do_push, do_pop;

  assign full_o  = (level_q == (PW+1)'(C_DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk) begin
    if (!reset_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      level_q <= level_q + (PW+1)'(1);
      else if (!do_push && do_pop) level_q <= level_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dma_2d_desc_scheduler.sv
// Descriptor sequencer for the 2D DMA: queues descriptors, validates them,
// starts read/write masters together and waits for both completions.
module dma_2d_desc_scheduler
  import dma_2d_pkg::*;
#(
  parameter int unsigned C_DESC_DEPTH     = 4,
  parameter int unsigned C_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned C_CNT_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_desc_valid,
  output logic                          o_desc_ready,
  input  logic [31:0]                   i_desc_src,
  input  logic [31:0]                   i_desc_dst,
  input  logic [31:0]                   i_desc_width,
  input  logic [31:0]                   i_desc_height,
  input  logic [31:0]                   i_desc_src_stride,
  input  logic [31:0]                   i_desc_dst_stride,
  output logic                          o_rd_start,
  output logic                          o_wr_start,
  output logic [31:0]                   o_src_addr,
  output logic [31:0]                   o_dst_addr,
  output logic [31:0]                   o_img_width,
  output logic [31:0]                   o_img_height,
  output logic [31:0]                   o_src_stride,
  output logic [31:0]                   o_dst_stride,
  input  logic                          i_read_done,
  input  logic                          i_write_done,
  input  logic                          i_err_clear,
  output logic                          o_busy,
  output logic                          o_irq,
  output logic [1:0]                    o_err,
  output logic [C_CNT_WIDTH-1:0]        o_done_count,
  output logic [$clog2(C_DESC_DEPTH):0] o_queue_level
);

  localparam bit          TO_EN   = (C_TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(C_TIMEOUT_CYCLES - 1) : '0;

  state_t                 state_q, state_d;
  desc_t                  act_q, act_d;
  logic [1:0]             err_q, err_d;
  logic                   start_q, start_d;
  logic                   irq_q, irq_d;
  logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]            to_q, to_d;
  logic                   rd_seen_q, rd_seen_d, wr_seen_q, wr_seen_d;
  logic                   rd_prev_q, wr_prev_q;
  logic                   rd_edge, wr_edge;

  logic [DESC_W-1:0]      push_data, fifo_dout;
  logic                   fifo_full, fifo_empty, fifo_pop, fifo_flush, fifo_push;

  always_comb begin
    push_data = '0;
    push_data[OFF_SRC     +: 32] = i_desc_src;
    push_data[OFF_DST     +: 32] = i_desc_dst;
    push_data[OFF_WIDTH   +: 32] = i_desc_width;
    push_data[OFF_HEIGHT  +: 32] = i_desc_height;
    push_data[OFF_SSTRIDE +: 32] = i_desc_src_stride;
    push_data[OFF_DSTRIDE +: 32] = i_desc_dst_stride;
  end

  assign o_desc_ready = ~fifo_full & (state_q != ST_ERR);
  assign fifo_push    = i_desc_valid & o_desc_ready;

  dma_desc_fifo #(
    .C_DEPTH (C_DESC_DEPTH),
    .C_W     (DESC_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_i  (push_data),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (o_queue_level)
  );

  // Only fresh rising edges count, so levels held over from a prior transfer are ignored.
  assign rd_edge = i_read_done  & ~rd_prev_q;
  assign wr_edge = i_write_done & ~wr_prev_q;

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    err_d      = err_q;
    start_d    = 1'b0;
    irq_d      = 1'b0;
    cnt_d      = cnt_q;
    to_d       = to_q;
    rd_seen_d  = rd_seen_q;
    wr_seen_d  = wr_seen_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          act_d    = desc_t'(fifo_dout);
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (act_q.width == '0 || act_q.height == '0 || act_q.width[1:0] != 2'b00 ||
            act_q.src_stride < act_q.width || act_q.dst_stride < act_q.width) begin
          err_d   = ERR_DESC;
          state_d = ST_ERR;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        start_d   = 1'b1;
        rd_seen_d = 1'b0;
        wr_seen_d = 1'b0;
        to_d      = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        rd_seen_d = rd_seen_q | rd_edge;
        wr_seen_d = wr_seen_q | wr_edge;
        if (rd_seen_d && wr_seen_d) begin
          state_d = ST_DONE;
        end else if (TO_EN && to_q == TO_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_ERR;
        end else begin
          to_d = to_q + 32'd1;
        end
      end
      ST_DONE: begin
        irq_d   = 1'b1;
        cnt_d   = cnt_q + C_CNT_WIDTH'(1);
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        fifo_flush = 1'b1;
        if (i_err_clear) begin
          err_d   = ERR_NONE;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      act_q     <= '0;
      err_q     <= ERR_NONE;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
      cnt_q     <= '0;
      to_q      <= '0;
      rd_seen_q <= 1'b0;
      wr_seen_q <= 1'b0;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      err_q     <= err_d;
      start_q   <= start_d;
      irq_q     <= irq_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      rd_seen_q <= rd_seen_d;
      wr_seen_q <= wr_seen_d;
      rd_prev_q <= i_read_done;
      wr_prev_q <= i_write_done;
    end
  end

  assign o_rd_start   = start_q;
  assign o_wr_start   = start_q;
  assign o_irq        = irq_q;
  assign o_err        = err_q;
  assign o_done_count = cnt_q;
  assign o_busy       = state_q inside {ST_CHECK, ST_START, ST_WAIT, ST_DONE};
  assign o_src_addr   = act_q.src;
  assign o_dst_addr   = act_q.dst;
  assign o_img_width  = act_q.width;
  assign o_img_height = act_q.height;
  assign o_src_stride = act_q.src_stride;
  assign o_dst_stride = act_q.dst_stride;

endmodule

// File: tb/tb_dma_2d_desc_scheduler.sv
// Scoreboard bench for dma_2d_desc_scheduler: accepted descriptors queue up
// as expected start transactions; a monitor checks starts and completions.
module tb_dma_2d_desc_scheduler;

  localparam int DEPTH = 4;
  localparam int TO    = 20;
  localparam int CW    = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_desc_valid = 1'b0;
  logic        o_desc_ready;
  logic [31:0] i_desc_src = '0, i_desc_dst = '0, i_desc_width = '0, i_desc_height = '0;
  logic [31:0] i_desc_src_stride = '0, i_desc_dst_stride = '0;
  logic        o_rd_start, o_wr_start;
  logic [31:0] o_src_addr, o_dst_addr, o_img_width, o_img_height, o_src_stride, o_dst_stride;
  logic        i_read_done = 1'b0, i_write_done = 1'b0, i_err_clear = 1'b0;
  logic        o_busy, o_irq;
  logic [1:0]  o_err;
  logic [CW-1:0] o_done_count;
  logic [$clog2(DEPTH):0] o_queue_level;

  always #5 clk = ~clk;

  dma_2d_desc_scheduler #(
    .C_DESC_DEPTH     (DEPTH),
    .C_TIMEOUT_CYCLES (TO),
    .C_CNT_WIDTH      (CW)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .i_desc_valid (i_desc_valid), .o_desc_ready (o_desc_ready),
    .i_desc_src (i_desc_src), .i_desc_dst (i_desc_dst),
    .i_desc_width (i_desc_width), .i_desc_height (i_desc_height),
    .i_desc_src_stride (i_desc_src_stride), .i_desc_dst_stride (i_desc_dst_stride),
    .o_rd_start (o_rd_start), .o_wr_start (o_wr_start),
    .o_src_addr (o_src_addr), .o_dst_addr (o_dst_addr),
    .o_img_width (o_img_width), .o_img_height (o_img_height),
    .o_src_stride (o_src_stride), .o_dst_stride (o_dst_stride),
    .i_read_done (i_read_done), .i_write_done (i_write_done),
    .i_err_clear (i_err_clear), .o_busy (o_busy), .o_irq (o_irq),
    .o_err (o_err), .o_done_count (o_done_count), .o_queue_level (o_queue_level)
  );

  typedef struct {
    logic [31:0] src, dst, w, h, ss, ds;
  } desc_s;

  desc_s exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    irq_allowed = 0;
  int    exp_done = 0;
  int    total_good = 0;
  bit    resp_en = 1'b1;
  bit    saw_full = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit desc_ok(input desc_s d);
    return (d.w != 0) && (d.h != 0) && (d.w % 4 == 0) && (d.ss >= d.w) && (d.ds >= d.w);
  endfunction

  function automatic desc_s make_good();
    desc_s d;
    d.src = $urandom;
    d.dst = $urandom;
    d.w   = 4 * $urandom_range(1, 64);
    d.h   = $urandom_range(1, 16);
    d.ss  = d.w + 4 * $urandom_range(0, 8);
    d.ds  = d.w + 4 * $urandom_range(0, 8);
    return d;
  endfunction

  // Drive a descriptor until accepted; the model only expects descriptors
  // that are valid and not destined to be flushed or reset away.
  task automatic push(input desc_s d, input bit track);
    int n = 0;
    @(negedge clk);
    i_desc_valid = 1'b1;
    i_desc_src = d.src; i_desc_dst = d.dst; i_desc_width = d.w; i_desc_height = d.h;
    i_desc_src_stride = d.ss; i_desc_dst_stride = d.ds;
    while (!o_desc_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", o_desc_ready, 1'b1);
    @(posedge clk);
    if (track && desc_ok(d)) begin
      exp_q.push_back(d);
      total_good++;
    end
    #1 i_desc_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!o_rd_start && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("start_seen", o_rd_start, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || o_busy || o_queue_level != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", (exp_q.size() == 0 && !o_busy && o_queue_level == 0), 1'b1);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (o_rd_start) begin
        check("wr_start_with_rd", o_wr_start, 1'b1);
        check("busy_at_start", o_busy, 1'b1);
        check("start_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          desc_s e;
          e = exp_q.pop_front();
          check("src_addr",   o_src_addr,   e.src);
          check("dst_addr",   o_dst_addr,   e.dst);
          check("img_width",  o_img_width,  e.w);
          check("img_height", o_img_height, e.h);
          check("src_stride", o_src_stride, e.ss);
          check("dst_stride", o_dst_stride, e.ds);
        end
      end else if (o_wr_start) begin
        check("wr_start_alone", o_wr_start, 1'b0);
      end
      if (o_irq) begin
        check("irq_allowed", irq_allowed > 0, 1'b1);
        if (irq_allowed > 0) irq_allowed--;
        exp_done++;
        check("done_count", o_done_count, 64'(exp_done % (1 << CW)));
      end
      if (o_queue_level == DEPTH) begin
        saw_full = 1'b1;
        check("ready_when_full", o_desc_ready, 1'b0);
      end
    end
  end

  // Master model: after a start, drop both done levels, then raise each after a random delay.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && resp_en && o_rd_start) begin
        int dr, dw, mx;
        dr = $urandom_range(1, 12);
        dw = $urandom_range(1, 12);
        mx = (dr > dw) ? dr : dw;
        i_read_done  = 1'b0;
        i_write_done = 1'b0;
        for (int c = 1; c <= mx; c++) begin
          @(negedge clk);
          if (c == dr) i_read_done = 1'b1;
          if (c == dw) i_write_done = 1'b1;
          if (c == mx) irq_allowed++;
        end
      end
    end
  end

  initial begin
    int n;
    int cnt_before;
    desc_s d;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", o_desc_ready, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_irq", o_irq, 1'b0);
    check("rst_err", o_err, 2'b00);
    check("rst_done_count", o_done_count, '0);
    check("rst_level", o_queue_level, '0);
    check("rst_start", {o_rd_start, o_wr_start}, 2'b00);
    check("rst_src", o_src_addr, '0);
    check("rst_width", o_img_width, '0);
    @(negedge clk);
    reset_n = 1'b1;

    d.src = 32'h1000; d.dst = 32'h8000; d.w = 64; d.h = 4; d.ss = 256; d.ds = 256;
    push(d, 1'b1);
    wait_start(n);
    check("start_latency", n, 3);
    wait_idle();
    check("single_done_count", o_done_count, 1);
    check("single_busy", o_busy, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      push(make_good(), 1'b1);
    end
    wait_idle();
    check("queue_reached_full", saw_full, 1'b1);
    check("done_total", o_done_count, total_good);

    d = make_good();
    d.w = 6; d.ss = 64; d.ds = 64;
    push(d, 1'b1);
    push(make_good(), 1'b0);
    repeat (4) @(negedge clk);
    check("bad_err", o_err, 2'b01);
    check("bad_level", o_queue_level, '0);
    check("bad_ready", o_desc_ready, 1'b0);
    check("bad_busy", o_busy, 1'b0);
    i_err_clear = 1'b1;
    @(posedge clk);
    #1 i_err_clear = 1'b0;
    check("bad_cleared", o_err, 2'b00);
    check("bad_ready_back", o_desc_ready, 1'b1);
    check("bad_count", o_done_count, total_good);

    resp_en = 1'b0;
    @(negedge clk);
    i_read_done = 1'b1;
    i_write_done = 1'b1;
    cnt_before = int'(o_done_count);
    push(make_good(), 1'b1);
    wait_start(n);
    repeat (3) @(negedge clk);
    i_write_done = 1'b0;
    repeat (2) @(negedge clk);
    i_write_done = 1'b1;
    repeat (4) @(negedge clk);
    check("stale_still_busy", o_busy, 1'b1);
    i_read_done = 1'b0;
    @(negedge clk);
    irq_allowed++;
    i_read_done = 1'b1;
    wait_idle();
    check("stale_done_count", o_done_count, cnt_before + 1);

    push(make_good(), 1'b1);
    wait_start(n);
    n = 0;
    while (o_err == 2'b00 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("timeout_cycles", n, TO);
    check("timeout_err", o_err, 2'b10);
    check("timeout_busy", o_busy, 1'b0);
    check("timeout_count", o_done_count, cnt_before + 1);
    @(negedge clk);
    i_err_clear = 1'b1;
    @(posedge clk);
    #1 i_err_clear = 1'b0;
    check("timeout_cleared", o_err, 2'b00);

    push(make_good(), 1'b1);
    wait_start(n);
    push(make_good(), 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_ready", o_desc_ready, 1'b1);
    check("mid_rst_level", o_queue_level, '0);
    check("mid_rst_irq", o_irq, 1'b0);
    check("mid_rst_err", o_err, 2'b00);
    check("mid_rst_count", o_done_count, '0);
    check("mid_rst_dst", o_dst_addr, '0);
    exp_done = 0;
    total_good = 0;
    @(negedge clk);
    reset_n = 1'b1;

    resp_en = 1'b1;
    push(make_good(), 1'b1);
    wait_idle();
    check("post_rst_count", o_done_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/dma_2d_desc_scheduler.md
Name: dma_2d_desc_scheduler

Overview:
Descriptor-driven sequencer for the 2D DMA engine. It queues 2D transfer descriptors from the control plane, validates each one, and starts the read and write masters together with a matched geometry. It waits for both masters to complete, then raises completion status and an interrupt pulse. It sits between the AXI-Lite register bank and the Read_Master/Write_Master pair.

Parameters:
C_DESC_DEPTH, 4, descriptor queue depth (power of 2, >=2)
C_TIMEOUT_CYCLES, 1000000, max cycles waiting for both done signals; 0 disables the timeout
C_CNT_WIDTH, 16, width of the completed-descriptor counter

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
i_desc_valid  in  1  descriptor push request
o_desc_ready  out  1  queue can accept a descriptor
i_desc_src  in  32  source base byte address
i_desc_dst  in  32  destination base byte address
i_desc_width  in  32  bytes per line
i_desc_height  in  32  number of lines
i_desc_src_stride  in  32  source line pitch in bytes
i_desc_dst_stride  in  32  destination line pitch in bytes
o_rd_start  out  1  one-cycle start pulse to the read master
o_wr_start  out  1  one-cycle start pulse to the write master
o_src_addr, o_dst_addr, o_img_width, o_img_height, o_src_stride, o_dst_stride  out  32 each  active descriptor fields, stable from the start pulse until return to IDLE
i_read_done  in  1  read master done (level; low after its start)
i_write_done  in  1  write master done (level; low after its start)
i_err_clear  in  1  clears the error state
o_busy  out  1  descriptor active (states CHECK through DONE)
o_irq  out  1  one-cycle pulse per completed descriptor
o_err  out  2  error code: 00 none, 01 bad descriptor, 10 timeout
o_done_count  out  C_CNT_WIDTH  completed descriptors, wraps modulo 2^C_CNT_WIDTH
o_queue_level  out  $clog2(C_DESC_DEPTH)+1  occupied queue entries

Behaviour:
- Reset: all outputs are 0, except o_desc_ready, which is 1. Queue is empty, state is IDLE, active registers are 0.
- Push occurs when i_desc_valid && o_desc_ready. o_desc_ready = !full && state!=ERR. A push and a pop in the same cycle are legal; the level is unchanged.
- FSM:
  - IDLE: if queue non-empty, pop the head into the active registers and go to CHECK.
  - CHECK: if width==0, height==0, width[1:0]!=0, src_stride<width or dst_stride<width, set o_err=01 and go to ERR. Otherwise go to START.
  - START: assert o_rd_start and o_wr_start for this cycle only. Clear the rd_seen/wr_seen flags and the timeout counter. Go to WAIT.
  - WAIT: set rd_seen on a rising edge of i_read_done and wr_seen on a rising edge of i_write_done. Rising edge = current high && registered previous low. Levels left over from a prior transfer never count. When both are seen (including the same cycle), go to DONE. If C_TIMEOUT_CYCLES!=0 and the counter reaches C_TIMEOUT_CYCLES-1 without both seen, set o_err=10 and go to ERR.
  - DONE: o_irq=1 for one cycle, o_done_count+1, go to IDLE.
  - ERR: flush the queue (level becomes 0 in the cycle after entry) and drop pushes. When i_err_clear=1, clear o_err and go to IDLE.
- Latency: a descriptor accepted at clock edge N into an empty queue with the FSM in IDLE gives a start pulse in the cycle after edge N+3 (pop at N+1, CHECK, START).
- Back-to-back: DONE to IDLE to the next pop. Minimum gap between start pulses is 4 cycles plus transfer time.
- i_err_clear outside ERR is ignored. Reset mid-transfer aborts immediately; no irq is generated.
- Done counter and queue pointers wrap naturally; the level counter is one bit wider than the pointers.

Decomposition:
- Package dma_2d_pkg holds the state encoding localparams (IDLE, CHECK, START, WAIT, DONE, ERR), error codes ERR_NONE/ERR_DESC/ERR_TIMEOUT, and a 192-bit descriptor bundle width constant with field offsets.
- One sub-module, dma_desc_fifo: a synchronous FIFO, C_DESC_DEPTH x 192 bits, with push/pop/flush, full/empty and level outputs.

Test Plan:
- Single descriptor (src=0x1000, dst=0x8000, w=64, h=4, strides=256): push, then pulse read_done and, 10 cycles later, write_done. Required: both starts high in the same single cycle, 3 cycles after acceptance; o_irq pulses once; o_done_count=1; o_busy low afterwards.
- Queue fill: push 5 descriptors with done signals held off. Required: o_desc_ready drops once the queue reports full; the 5th push is accepted only after the first pop; all 5 complete in order, with the o_dst_addr sequence matching.
- Bad descriptor, width=6. Required: no start pulse, o_err=01, queue flushed, o_desc_ready=0. i_err_clear returns to IDLE with o_err=00.
- Stale done: hold i_write_done high across the start, then drop and re-raise it. Required: DONE is reached only after the re-raise and the read_done edge.
- Timeout with C_TIMEOUT_CYCLES=20 and no done signals. Required: o_err=10 exactly 20 cycles after the start pulse, no irq.
- Reset asserted during WAIT. Required: all outputs return to reset values on the next edge and the queue is empty.
